// File: rtl/stack_sequencer.sv
// Arbitrates core and interrupt-unit stack transactions onto one push/pop stack port,
// with fixed interrupt priority, overflow/underflow detection and a saturating depth count.
module stack_sequencer #(
    parameter int DATA_W  = 10,
    parameter int DEPTH_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req,
    input  logic               cpu_op,
    input  logic [DATA_W-1:0]  cpu_data,
    output logic               cpu_ack,
    input  logic               irq_req,
    input  logic               irq_op,
    input  logic [DATA_W-1:0]  irq_data,
    output logic               irq_ack,
    output logic [DATA_W-1:0]  rdata,
    output logic               stk_en,
    output logic               stk_op,
    output logic [DATA_W-1:0]  stk_din,
    input  logic [DATA_W-1:0]  stk_dout,
    input  logic               stk_full,
    input  logic               stk_empty,
    output logic               err,
    output logic [1:0]         err_code,
    output logic [DEPTH_W-1:0] depth
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        READ,
        ACK,
        ERR
    } state_t;

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

    state_t               state_q, state_d;
    logic                 owner_q, owner_d;   // 1 = interrupt unit, 0 = core
    logic                 op_q, op_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [1:0]           err_code_q, err_code_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            op_q       <= 1'b0;
            data_q     <= '0;
            rdata_q    <= '0;
            err_code_q <= '0;
            depth_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            op_q       <= op_d;
            data_q     <= data_d;
            rdata_q    <= rdata_d;
            err_code_q <= err_code_d;
            depth_q    <= depth_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        op_d       = op_q;
        data_d     = data_q;
        rdata_d    = rdata_q;
        err_code_d = err_code_q;
        depth_d    = depth_q;
        unique case (state_q)
            IDLE: begin
                if (irq_req || cpu_req) begin
                    owner_d = irq_req;
                    op_d    = irq_req ? irq_op : cpu_op;
                    data_d  = irq_req ? irq_data : cpu_data;
                    // Code is loaded on entry so it is already visible in the ERR cycle
                    if (op_d && stk_full) begin
                        state_d    = ERR;
                        err_code_d = 2'b01;
                    end else if (!op_d && stk_empty) begin
                        state_d    = ERR;
                        err_code_d = 2'b10;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: state_d = op_q ? ACK : READ;
            READ: begin
                rdata_d = stk_dout;
                state_d = ACK;
            end
            ACK: begin
                if (op_q && depth_q != DEPTH_MAX) begin
                    depth_d = depth_q + DEPTH_W'(1);
                end else if (!op_q && depth_q != '0) begin
                    depth_d = depth_q - DEPTH_W'(1);
                end
                state_d = IDLE;
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stk_en   = (state_q == ISSUE);
        stk_op   = (state_q == ISSUE) ? op_q : 1'b0;
        stk_din  = (state_q == ISSUE) ? data_q : '0;
        cpu_ack  = (state_q == ACK || state_q == ERR) && !owner_q;
        irq_ack  = (state_q == ACK || state_q == ERR) && owner_q;
        err      = (state_q == ERR);
        err_code = err_code_q;
        rdata    = rdata_q;
        depth    = depth_q;
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Randomized and directed bench for stack_sequencer: a behavioural stack drives the
// stack port, and a transaction-level queue model predicts acks, rdata, errors and depth.
module tb_stack_sequencer;

    localparam int DATA_W  = 10;
    localparam int DEPTH_W = 5;
    localparam int DMAX    = (1 << DEPTH_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               cpu_req, cpu_op, irq_req, irq_op;
    logic [DATA_W-1:0]  cpu_data, irq_data;
    logic               cpu_ack, irq_ack;
    logic [DATA_W-1:0]  rdata;
    logic               stk_en, stk_op;
    logic [DATA_W-1:0]  stk_din;
    logic [DATA_W-1:0]  stk_dout;
    logic               stk_full, stk_empty;
    logic               err;
    logic [1:0]         err_code;
    logic [DEPTH_W-1:0] depth;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stack_sequencer #(.DATA_W(DATA_W), .DEPTH_W(DEPTH_W)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_op(cpu_op), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
        .irq_req(irq_req), .irq_op(irq_op), .irq_data(irq_data), .irq_ack(irq_ack),
        .rdata(rdata), .stk_en(stk_en), .stk_op(stk_op), .stk_din(stk_din),
        .stk_dout(stk_dout), .stk_full(stk_full), .stk_empty(stk_empty),
        .err(err), .err_code(err_code), .depth(depth)
    );

    // Behavioural stack: capacity is adjustable so the depth counter can be pushed past 15
    logic [DATA_W-1:0] env_mem [0:63];
    int env_cnt = 0;
    int env_cap = 15;

    always @(posedge clk) begin
        if (rst) begin
            env_cnt  <= 0;
            stk_dout <= '0;
        end else if (stk_en) begin
            if (stk_op) begin
                if (env_cnt < env_cap) begin
                    env_mem[env_cnt] <= stk_din;
                    env_cnt <= env_cnt + 1;
                end
            end else if (env_cnt > 0) begin
                stk_dout <= env_mem[env_cnt-1];
                env_cnt  <= env_cnt - 1;
            end
        end
    end

    assign stk_full  = (env_cnt >= env_cap);
    assign stk_empty = (env_cnt == 0);

    // Reference model
    logic [DATA_W-1:0] mdl_q [$];
    int                mdl_depth = 0;
    logic [1:0]        mdl_code  = 2'b00;
    logic [DATA_W-1:0] mdl_rdata = '0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        cpu_req = 1'b0; irq_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mdl_q.delete();
        mdl_depth = 0;
        mdl_code  = 2'b00;
        mdl_rdata = '0;
    endtask

    task automatic do_txn(input bit is_irq, input bit op, input logic [DATA_W-1:0] d);
        bit                exp_err;
        int                exp_lat;
        logic [DATA_W-1:0] exp_rd;
        bit                got;
        logic              own_ack, oth_ack;
        exp_err = op ? (mdl_q.size() >= env_cap) : (mdl_q.size() == 0);
        exp_lat = exp_err ? 1 : (op ? 2 : 3);
        exp_rd  = (!exp_err && !op) ? mdl_q[$] : '0;
        got     = 1'b0;
        @(negedge clk);
        if (is_irq) begin irq_req = 1'b1; irq_op = op; irq_data = d; end
        else        begin cpu_req = 1'b1; cpu_op = op; cpu_data = d; end
        for (int n = 1; n <= 6 && !got; n++) begin
            @(negedge clk);
            if (n == 1) begin
                checks++;
                if (stk_en !== !exp_err) begin
                    failures++;
                    $display("FAIL issue_en got=%0b exp=%0b", stk_en, !exp_err);
                end
                if (!exp_err) begin
                    checks++;
                    if ({stk_op, stk_din} !== {op, d}) begin
                        failures++;
                        $display("FAIL issue_word got=%0b/%0h exp=%0b/%0h", stk_op, stk_din, op, d);
                    end
                end
                // Request inputs change after the grant; the latched transaction must not
                if (is_irq) begin irq_op = ~op; irq_data = DATA_W'($urandom); end
                else        begin cpu_op = ~op; cpu_data = DATA_W'($urandom); end
            end
            own_ack = is_irq ? irq_ack : cpu_ack;
            oth_ack = is_irq ? cpu_ack : irq_ack;
            checks++;
            if (oth_ack !== 1'b0) begin
                failures++;
                $display("FAIL non_owner_ack got=%0b exp=0 cycle=%0d", oth_ack, n);
            end
            if (own_ack === 1'b1) begin
                got = 1'b1;
                checks++;
                if (n != exp_lat) begin
                    failures++;
                    $display("FAIL ack_latency got=%0d exp=%0d", n, exp_lat);
                end
                checks++;
                if (err !== exp_err) begin
                    failures++;
                    $display("FAIL err_strobe got=%0b exp=%0b", err, exp_err);
                end
                if (exp_err) begin
                    mdl_code = op ? 2'b01 : 2'b10;
                end else if (op) begin
                    mdl_q.push_back(d);
                    if (mdl_depth < DMAX) mdl_depth++;
                end else begin
                    mdl_rdata = mdl_q.pop_back();
                    if (mdl_depth > 0) mdl_depth--;
                end
                checks++;
                if (err_code !== mdl_code) begin
                    failures++;
                    $display("FAIL err_code got=%0b exp=%0b", err_code, mdl_code);
                end
                if (!exp_err && !op) begin
                    checks++;
                    if (rdata !== exp_rd) begin
                        failures++;
                        $display("FAIL pop_rdata got=%0h exp=%0h", rdata, exp_rd);
                    end
                end
                if (is_irq) irq_req = 1'b0; else cpu_req = 1'b0;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout got=none exp=latency %0d", exp_lat);
            cpu_req = 1'b0; irq_req = 1'b0;
        end
        @(negedge clk);
        checks++;
        if ({depth, rdata, err_code, err, stk_en, stk_din} !==
            {DEPTH_W'(mdl_depth), mdl_rdata, mdl_code, 1'b0, 1'b0, {DATA_W{1'b0}}}) begin
            failures++;
            $display("FAIL idle_state got=depth %0d rdata %0h code %0b err %0b en %0b din %0h exp=depth %0d rdata %0h code %0b",
                     depth, rdata, err_code, err, stk_en, stk_din, mdl_depth, mdl_rdata, mdl_code);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({cpu_ack, irq_ack, err, stk_en, stk_op, stk_din, rdata, err_code, depth} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h exp=0",
                     {cpu_ack, irq_ack, err, stk_en, stk_op, stk_din, rdata, err_code, depth});
        end
    endtask

    task automatic test_basic();
        apply_reset();
        do_txn(1'b0, 1'b1, 10'h155);
        do_txn(1'b0, 1'b1, 10'h2AA);
        do_txn(1'b0, 1'b0, '0);
        do_txn(1'b1, 1'b0, '0);
    endtask

    task automatic test_priority();
        int irq_at, cpu_at;
        logic [DATA_W-1:0] cd;
        cd = DATA_W'($urandom);
        irq_at = 0; cpu_at = 0;
        @(negedge clk);
        irq_req = 1'b1; irq_op = 1'b1; irq_data = 10'h3FF;
        cpu_req = 1'b1; cpu_op = 1'b1; cpu_data = cd;
        for (int n = 1; n <= 10 && cpu_at == 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                checks++;
                if (stk_din !== 10'h3FF) begin
                    failures++;
                    $display("FAIL prio_first_word got=%0h exp=3ff", stk_din);
                end
            end
            if (irq_ack === 1'b1 && irq_at == 0) begin irq_at = n; irq_req = 1'b0; end
            if (cpu_ack === 1'b1 && cpu_at == 0) begin cpu_at = n; cpu_req = 1'b0; end
        end
        cpu_req = 1'b0; irq_req = 1'b0;
        checks++;
        if (irq_at != 2) begin
            failures++;
            $display("FAIL prio_irq_ack got=%0d exp=2", irq_at);
        end
        checks++;
        if (cpu_at != 5) begin
            failures++;
            $display("FAIL prio_cpu_ack got=%0d exp=5", cpu_at);
        end
        mdl_q.push_back(10'h3FF);
        mdl_q.push_back(cd);
        mdl_depth = (mdl_depth + 2 > DMAX) ? DMAX : mdl_depth + 2;
        @(negedge clk);
        checks++;
        if (depth !== DEPTH_W'(mdl_depth)) begin
            failures++;
            $display("FAIL prio_depth got=%0d exp=%0d", depth, mdl_depth);
        end
        do_txn(1'b0, 1'b0, '0);
        do_txn(1'b1, 1'b0, '0);
    endtask

    task automatic test_underflow();
        apply_reset();
        do_txn(1'b0, 1'b0, '0);
        do_txn(1'b1, 1'b0, '0);
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 15; i++) do_txn(i[0], 1'b1, DATA_W'($urandom));
        do_txn(1'b0, 1'b1, 10'h111);
        for (int i = 0; i < 15; i++) do_txn(i[1], 1'b0, '0);
        do_txn(1'b0, 1'b0, '0);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        do_txn(1'b0, 1'b1, 10'h0AB);
        @(negedge clk);
        cpu_req = 1'b1; cpu_op = 1'b0; cpu_data = '0;
        @(negedge clk);
        checks++;
        if (stk_en !== 1'b1) begin
            failures++;
            $display("FAIL midrst_issue got=%0b exp=1", stk_en);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cpu_req = 1'b0;
        mdl_q.delete();
        mdl_depth = 0; mdl_code = 2'b00; mdl_rdata = '0;
        checks++;
        if ({cpu_ack, irq_ack, err, stk_en, stk_op, stk_din, rdata, err_code, depth} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs got=%0h exp=0",
                     {cpu_ack, irq_ack, err, stk_en, stk_op, stk_din, rdata, err_code, depth});
        end
        @(negedge clk);
        checks++;
        if (cpu_ack !== 1'b0) begin
            failures++;
            $display("FAIL midrst_late_ack got=%0b exp=0", cpu_ack);
        end
        do_txn(1'b0, 1'b1, 10'h1C3);
        do_txn(1'b0, 1'b0, '0);
    endtask

    task automatic test_saturation();
        apply_reset();
        env_cap = 40;
        for (int i = 0; i < 34; i++) do_txn(i[0], 1'b1, DATA_W'($urandom));
        for (int i = 0; i < 34; i++) do_txn(i[0], 1'b0, '0);
        do_txn(1'b1, 1'b0, '0);
        env_cap = 15;
        apply_reset();
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 80; i++) begin
            do_txn(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6), DATA_W'($urandom));
        end
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0; cpu_op = 1'b0; cpu_data = '0;
        irq_req = 1'b0; irq_op = 1'b0; irq_data = '0;
        test_reset();
        test_basic();
        test_priority();
        test_underflow();
        test_overflow();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stack_sequencer.md
STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 Parameter: DATA_W, 10, width of every stack word.
REQ-002 Parameter: DEPTH_W, 5, width of the depth output.
REQ-003 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: cpu_req  in  1  core requests a stack transaction.
REQ-006 Port: cpu_op  in  1  core operation: 1 = push (CALL), 0 = pop (RET).
REQ-007 Port: cpu_data  in  DATA_W  core push word.
REQ-008 Port: cpu_ack  out  1  one-cycle completion strobe to the core.
REQ-009 Port: irq_req  in  1  interrupt unit requests a stack transaction.
REQ-010 Port: irq_op  in  1  interrupt operation: 1 = push (entry), 0 = pop (RETI).
REQ-011 Port: irq_data  in  DATA_W  interrupt push word.
REQ-012 Port: irq_ack  out  1  one-cycle completion strobe to the interrupt unit.
REQ-013 Port: rdata  out  DATA_W  popped word; valid in the ack cycle of a pop; held until the next pop completes.
REQ-014 Port: stk_en, stk_op  out  1, 1  stack enable and stack operation (1 = push, 0 = pop).
REQ-015 Port: stk_din  out  DATA_W  word to the stack.
REQ-016 Port: stk_dout  in  DATA_W  stack read data, registered by the stack on the pop edge.
REQ-017 Port: stk_full, stk_empty  in  1, 1  stack status flags.
REQ-018 Port: err  out  1  one-cycle error strobe.
REQ-019 Port: err_code  out  2  01 = overflow, 10 = underflow; held until the next error or reset.
REQ-020 Port: depth  out  DEPTH_W  count of successful pushes minus successful pops.

Function
REQ-021 The FSM SHALL have the states IDLE, ISSUE, READ, ACK and ERR.
REQ-022 In IDLE, with irq_req=1, the block SHALL grant the interrupt unit (fixed priority); otherwise, with cpu_req=1, it SHALL grant the core; otherwise it SHALL stay in IDLE.
REQ-023 On a grant, the block SHALL latch the owner, op and data; later changes on the request inputs SHALL NOT affect the transaction.
REQ-024 On a grant, a push with stk_full=1 or a pop with stk_empty=1 SHALL go to ERR; every other grant SHALL go to ISSUE.
REQ-025 ISSUE SHALL last one cycle and drive stk_en=1, stk_op=latched op and stk_din=latched data; stk_en SHALL be 0 in every other state.
REQ-026 From ISSUE, a push SHALL go to ACK and a pop SHALL go to READ.
REQ-027 READ SHALL capture stk_dout into rdata and go to ACK.
REQ-028 ACK SHALL pulse the owner's ack for one cycle and update depth (push +1, pop -1), then go to IDLE.
REQ-029 ERR SHALL pulse the owner's ack and err in the same cycle, load err_code, leave depth and rdata unchanged, never assert stk_en, then go to IDLE.
REQ-030 Latency from the grant cycle to the ack cycle SHALL be: push 2 cycles, pop 3 cycles, error 1 cycle.
REQ-031 A requester SHALL drop req by the edge that samples its ack; req high in IDLE is a new request.
REQ-032 The non-owner's ack SHALL stay 0; a pending cpu_req SHALL wait, unstarved only when irq_req is low in IDLE.
REQ-033 depth SHALL saturate at 0 and at 2^DEPTH_W-1 and SHALL NOT wrap.
REQ-034 stk_din SHALL be 0 outside ISSUE.

Reset
REQ-035 rst=1 at a clock edge SHALL force IDLE, all outputs to 0 and depth to 0, with priority over any other event.
REQ-036 Reset mid-transaction SHALL abort it with no ack; the stack's own reset is tied to the same rst.

Verification
REQ-037 Core push 0x155 into an empty stack -> stk_en=1/stk_op=1/stk_din=0x155 in the cycle after the grant; cpu_ack 2 cycles after the grant; depth=1.
REQ-038 Push 0x2AA, then core pop -> cpu_ack 3 cycles after the grant with rdata=0x2AA; depth back to the prior value.
REQ-039 cpu_req and irq_req both high in IDLE (irq push 0x3FF) -> irq served first, cpu_ack follows the irq transaction, cpu_ack=0 during the irq transaction.
REQ-040 Pop with stk_empty=1 -> ack and err in the cycle after the grant, err_code=10, no stk_en, depth unchanged.
REQ-041 15 pushes until stk_full=1, then a 16th push -> err_code=01, depth=15, stack contents intact (verified by 15 pops returning LIFO order).
REQ-042 rst asserted in the ISSUE cycle of a pop -> no ack, outputs 0, depth=0, the next request is served normally.
